ufm_sequencer: RTL and testbench

Job-level controller that sequences one `user_functional_module` instance. It buffers a 64-word input block from a valid/ready stream and issues a level-held `start`. It then feeds the module's LOAD_DATA phase one word per cycle and captures all 64 words the module presents during SAVE_DATA. Finally it drains the results to a valid/ready output stream with backpressure and runs a watchdog over every module phase.

---
 rtl/ufm_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_ufm_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufm_sequencer.sv
// Job controller for one user_functional_module: buffers an input block, drives
// LOAD, captures SAVE, drains results with backpressure, and guards every phase.
module ufm_sequencer #(
  parameter int unsigned N_WORDS = 64,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_start,
  output logic              job_busy,
  output logic              job_done,
  output logic              job_error,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              ufm_start,
  output logic [7:0]        ufm_data_in_addr,
  output logic [DATA_W-1:0] ufm_data_in,
  input  logic [7:0]        ufm_data_out_addr,
  input  logic [DATA_W-1:0] ufm_data_out,
  input  logic [3:0]        ufm_state
);
  localparam int unsigned AW = $clog2(N_WORDS);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(N_WORDS);
  localparam logic [15:0]   WD_LIMIT = 16'(TIMEOUT - 1);

  localparam logic [3:0] U_IDLE = 4'd0;
  localparam logic [3:0] U_LOAD = 4'd1;
  localparam logic [3:0] U_SAVE = 4'd3;
  localparam logic [3:0] U_DONE = 4'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_KICK, S_LOAD, S_WAIT, S_CAPT, S_RELEASE, S_DRAIN, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] ld_cnt_q, ld_cnt_d;
  logic [CW-1:0] cap_cnt_q, cap_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [15:0]   wd_q, wd_d;
  logic [3:0]    ufm_state_q;
  logic          ufm_start_q, ufm_start_d;
  logic          done_q, done_d;

  logic [DATA_W-1:0] inbuf  [N_WORDS];
  logic [DATA_W-1:0] outbuf [N_WORDS];

  logic s_fire, m_fire, cap_en, wd_active;

  always_comb begin
    s_ready          = (state_q == S_FILL);
    m_valid          = (state_q == S_DRAIN);
    m_last           = m_valid && (rd_cnt_q == LAST);
    m_data           = m_valid ? outbuf[rd_cnt_q[AW-1:0]] : '0;
    ufm_data_in      = inbuf[ld_cnt_q[AW-1:0]];
    ufm_data_in_addr = 8'(ld_cnt_q);
    ufm_start        = ufm_start_q;
    job_busy         = (state_q != S_IDLE) && (state_q != S_ERR);
    job_error        = (state_q == S_ERR);
    job_done         = done_q;
    s_fire           = s_ready && s_valid;
    m_fire           = m_valid && m_ready;
    // The first SAVE word arrives while still in S_WAIT, so capture covers both states.
    cap_en           = ((state_q == S_WAIT) || (state_q == S_CAPT)) &&
                       (ufm_state == U_SAVE) && (ufm_data_out_addr < 8'(N_WORDS));
    wd_active        = (state_q == S_KICK) || (state_q == S_LOAD) || (state_q == S_WAIT) ||
                       (state_q == S_CAPT) || (state_q == S_RELEASE);
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    ld_cnt_d    = ld_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    ufm_start_d = ufm_start_q;
    done_d      = 1'b0;
    wd_d        = '0;

    case (state_q)
      S_IDLE: begin
        wr_cnt_d  = '0;
        ld_cnt_d  = '0;
        cap_cnt_d = '0;
        rd_cnt_d  = '0;
        if (job_start) state_d = S_FILL;
      end
      S_FILL: begin
        if (s_fire) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST) begin
            state_d     = S_KICK;
            ld_cnt_d    = '0;
            ufm_start_d = 1'b1;
          end
        end
      end
      // The module's first LOAD cycle is observed here, so it already consumes word 0.
      S_KICK: begin
        if (ufm_state == U_LOAD) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ufm_state == U_LOAD) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LAST) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ufm_state == U_SAVE) state_d = S_CAPT;
      end
      S_CAPT: begin
        if (ufm_state != U_SAVE) state_d = (cap_cnt_q == FULL) ? S_RELEASE : S_ERR;
      end
      S_RELEASE: begin
        if (ufm_state == U_DONE) ufm_start_d = 1'b0;
        if ((ufm_state == U_IDLE) && !ufm_start_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (m_fire) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (m_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_ERR: begin
        if (job_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cap_en) cap_cnt_d = cap_cnt_q + 1'b1;

    if (wd_active && (wd_q == WD_LIMIT)) state_d = S_ERR;

    if ((state_d != state_q) || (ufm_state != ufm_state_q)) wd_d = '0;
    else if (wd_active) wd_d = wd_q + 16'd1;

    if ((state_d == S_IDLE) || (state_d == S_FILL) || (state_d == S_DRAIN) || (state_d == S_ERR))
      ufm_start_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_cnt_q    <= '0;
      ld_cnt_q    <= '0;
      cap_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      wd_q        <= '0;
      ufm_state_q <= '0;
      ufm_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wd_q        <= wd_d;
      ufm_state_q <= ufm_state;
      ufm_start_q <= ufm_start_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s_fire) inbuf[wr_cnt_q[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (cap_en) outbuf[ufm_data_out_addr[AW-1:0]] <= ufm_data_out;
  end

endmodule

// File: tb/tb_ufm_sequencer.sv
// Directed bench for ufm_sequencer with a behavioural stand-in for the module
// that inverts each loaded word.
module tb_ufm_sequencer;
  localparam int PROC = 5;
  localparam int M_NORMAL = 0, M_HANG = 1, M_SHORT = 2, M_JUNK = 3;

  logic        clk = 1'b0, rst = 1'b1, ufm_rst = 1'b0;
  logic        job_start = 1'b0, job_busy, job_done, job_error;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_ready = 1'b0, m_last;
  logic        ufm_start;
  logic [7:0]  ufm_data_in_addr, ufm_data_out_addr;
  logic [31:0] ufm_data_in, ufm_data_out;
  logic [3:0]  ufm_state;

  int total = 0, bad = 0;
  int done_cnt = 0, start_viol = 0, ld_err = 0;
  int mode = M_NORMAL;

  always #5 clk = ~clk;

  ufm_sequencer #(.N_WORDS(64), .DATA_W(32), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_busy(job_busy),
    .job_done(job_done), .job_error(job_error),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .ufm_start(ufm_start), .ufm_data_in_addr(ufm_data_in_addr), .ufm_data_in(ufm_data_in),
    .ufm_data_out_addr(ufm_data_out_addr), .ufm_data_out(ufm_data_out), .ufm_state(ufm_state)
  );

  // Module stand-in: IDLE, 64 LOAD, PROC PROCESS, SAVE (64 or 32 words), DONE until start drops.
  logic [3:0]  st;
  logic [7:0]  scnt;
  logic        junk;
  logic [31:0] mem [64];
  logic        stub_rst;
  assign stub_rst          = rst | ufm_rst;
  assign ufm_state         = st;
  assign ufm_data_out_addr = junk ? 8'd200 : scnt;
  assign ufm_data_out      = junk ? 32'hDEAD_BEEF : ~mem[scnt[5:0]];

  always @(posedge clk or posedge stub_rst) begin
    if (stub_rst) begin
      st <= 4'd0; scnt <= 8'd0; junk <= 1'b0;
    end else begin
      case (st)
        4'd0: if (ufm_start) begin st <= 4'd1; scnt <= 8'd0; end
        4'd1: if (scnt == 8'd63) begin st <= 4'd2; scnt <= 8'd0; end else scnt <= scnt + 8'd1;
        4'd2: if (mode != M_HANG) begin
                if (scnt == 8'(PROC - 1)) begin
                  st <= 4'd3; scnt <= 8'd0; junk <= (mode == M_JUNK);
                end else scnt <= scnt + 8'd1;
              end
        4'd3: if (junk) junk <= 1'b0;
              else if (scnt == ((mode == M_SHORT) ? 8'd31 : 8'd63)) st <= 4'd4;
              else scnt <= scnt + 8'd1;
        default: if (!ufm_start) st <= 4'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!stub_rst && st == 4'd1) begin
      mem[ufm_data_in_addr[5:0]] <= ufm_data_in;
      if (ufm_data_in_addr != scnt) ld_err <= ld_err + 1;
    end
  end

  always @(negedge clk) begin
    if (job_done === 1'b1) done_cnt <= done_cnt + 1;
    if (!rst && !job_error && st >= 4'd1 && st <= 4'd3 && ufm_start !== 1'b1)
      start_viol <= start_viol + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job();
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check("start_busy", 64'(job_busy), 64'd1);
    check("start_sready", 64'(s_ready), 64'd1);
  endtask

  task automatic fill(input logic [31:0] base, input bit gaps);
    int i = 0, cyc = 0;
    while (i < 64 && cyc < 2000) begin
      if (gaps && $urandom_range(1) == 0) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        s_data  = base + 32'(i);
        if (s_ready) i++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    check("fill_count", 64'(i), 64'd64);
    check("kick_start", 64'(ufm_start), 64'd1);
    check("kick_sready", 64'(s_ready), 64'd0);
    check("kick_addr", 64'(ufm_data_in_addr), 64'd0);
  endtask

  task automatic drain(input logic [31:0] base, input bit stall, input bit poke, input bit chain);
    int idx = 0, cyc = 0;
    bit prev_stall = 1'b0, first = 1'b1;
    logic [31:0] prev = '0, exp_w;
    while (idx < 64 && cyc < 3000) begin
      m_ready   = stall ? 1'($urandom_range(1)) : 1'b1;
      job_start = poke && (idx == 10);
      if (m_valid) begin
        exp_w = ~(base + 32'(idx));
        if (prev_stall) check("hold", 64'(m_data), 64'(prev));
        check("m_data", 64'(m_data), 64'(exp_w));
        check("m_last", 64'(m_last), 64'(idx == 63));
        if (first) check("drain_start_low", 64'(ufm_start), 64'd0);
        first      = 1'b0;
        prev_stall = !m_ready;
        prev       = m_data;
        if (m_ready) idx++;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready   = 1'b0;
    job_start = 1'b0;
    check("drain_count", 64'(idx), 64'd64);
    check("done_high", 64'(job_done), 64'd1);
    check("busy_after", 64'(job_busy), 64'd0);
    check("mvalid_after", 64'(m_valid), 64'd0);
    job_start = chain;
    @(negedge clk);
    job_start = 1'b0;
    check("done_pulse", 64'(job_done), 64'd0);
    check("sready_next", 64'(s_ready), 64'(chain));
  endtask

  task automatic wait_stub(input logic [3:0] want_st, input logic [7:0] want_cnt);
    int cyc = 0;
    while (!(st == want_st && scnt == want_cnt) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("wait_stub", 64'(st), 64'(want_st));
  endtask

  task automatic clear_error();
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check("clr_error", 64'(job_error), 64'd0);
    check("clr_busy", 64'(job_busy), 64'd0);
    @(negedge clk);
    check("clr_no_job", 64'(job_busy), 64'd0);
    check("clr_sready", 64'(s_ready), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(job_busy), 64'd0);
    check({tag, "_done"}, 64'(job_done), 64'd0);
    check({tag, "_err"}, 64'(job_error), 64'd0);
    check({tag, "_sready"}, 64'(s_ready), 64'd0);
    check({tag, "_mvalid"}, 64'(m_valid), 64'd0);
    check({tag, "_mlast"}, 64'(m_last), 64'd0);
    check({tag, "_mdata"}, 64'(m_data), 64'd0);
    check({tag, "_start"}, 64'(ufm_start), 64'd0);
    check({tag, "_addr"}, 64'(ufm_data_in_addr), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_idle("rst");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_rst");

    // Nominal job with ignored requests during LOAD and DRAIN.
    mode = M_NORMAL;
    start_job();
    fill(32'h0, 1'b0);
    wait_stub(4'd1, 8'd30);
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check("poke_busy", 64'(job_busy), 64'd1);
    check("poke_start", 64'(ufm_start), 64'd1);
    check("poke_addr", 64'(ufm_data_in_addr), 64'd31);
    drain(32'h0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("nom_idle", 64'(job_busy), 64'd0);
    check("nom_done_cnt", 64'(done_cnt), 64'd1);

    // Backpressure on both streams, plus an out-of-range SAVE address.
    mode = M_JUNK;
    start_job();
    fill(32'h1000, 1'b1);
    drain(32'h1000, 1'b1, 1'b0, 1'b0);
    check("bp_done_cnt", 64'(done_cnt), 64'd2);

    // Module hangs in PROCESS: watchdog reaches TIMEOUT-1, then one register stage.
    mode = M_HANG;
    start_job();
    fill(32'h2000, 1'b0);
    wait_stub(4'd2, 8'd0);
    n = 0;
    while (!job_error && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 64'(n), 64'd1025);
    check("timeout_err", 64'(job_error), 64'd1);
    check("timeout_start", 64'(ufm_start), 64'd0);
    check("timeout_busy", 64'(job_busy), 64'd0);
    check("timeout_sready", 64'(s_ready), 64'd0);
    ufm_rst = 1'b1;
    @(negedge clk);
    ufm_rst = 1'b0;
    mode = M_NORMAL;
    clear_error();

    // Module leaves SAVE after 32 words.
    mode = M_SHORT;
    start_job();
    fill(32'h3000, 1'b0);
    n = 0;
    while (!job_error && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("short_err", 64'(job_error), 64'd1);
    check("short_mvalid", 64'(m_valid), 64'd0);
    check("short_done_cnt", 64'(done_cnt), 64'd2);
    repeat (3) @(negedge clk);
    check("short_stub_idle", 64'(st), 64'd0);
    mode = M_NORMAL;
    clear_error();

    // Asynchronous reset in the middle of LOAD, then back-to-back jobs.
    start_job();
    fill(32'h4000, 1'b0);
    wait_stub(4'd1, 8'd20);
    check("mid_addr", 64'(ufm_data_in_addr), 64'd20);
    rst = 1'b1;
    #1;
    check_idle("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("arst_rel");
    start_job();
    fill(32'h5000, 1'b0);
    drain(32'h5000, 1'b0, 1'b0, 1'b1);
    fill(32'h6000, 1'b0);
    drain(32'h6000, 1'b0, 1'b0, 1'b0);
    check("b2b_done_cnt", 64'(done_cnt), 64'd4);
    check("start_window", 64'(start_viol), 64'd0);
    check("load_order", 64'(ld_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
